// File: rtl/traffic_pkg.sv
// Shared types and constants for the traffic-light controller and its countdown timer.
package traffic_pkg;

    localparam int TLEN_W = 5;

    localparam logic [TLEN_W-1:0] RED_LEN    = 5'd20;
    localparam logic [TLEN_W-1:0] YELLOW_LEN = 5'd3;
    localparam logic [TLEN_W-1:0] GREEN_LEN  = 5'd15;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } timer_state_t;

    // True when a remaining count c lies in the final warning window 1..w.
    function automatic logic in_window(input logic [TLEN_W-1:0] c,
                                       input logic [TLEN_W-1:0] w);
        return (c != '0) && (c <= w);
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Divides clk down to a one-cycle tick every TICK_DIV enabled cycles; clr restarts the period.
module tick_prescaler #(
    parameter logic [31:0] TICK_DIV = 32'd50_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int              CNT_W = $clog2(TICK_DIV + 32'd1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 32'd1);

    logic [CNT_W-1:0] r_cnt;

    assign tick = en && (r_cnt == LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (clr || tick) begin
            r_cnt <= '0;
        end else if (en) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/smart_timer.sv
// Freezable seconds countdown with expiry and final-window flicker pulses.
// Define SMART_TIMER_REMAIN_EN to expose the live count on t_remain.
module smart_timer
    import traffic_pkg::*;
#(
    parameter logic [31:0] TICK_DIV       = 32'd50_000_000,
    parameter logic [4:0]  FLICKER_WINDOW = 5'd5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              t_start,
    input  logic [TLEN_W-1:0] t_length,
    input  logic              t_freeze,
    output logic              t_done,
    output logic              t_flicker,
    output logic              t_busy
`ifdef SMART_TIMER_REMAIN_EN
    ,
    output logic [TLEN_W-1:0] t_remain
`endif
);

    timer_state_t      r_state;
    timer_state_t      w_next_state;
    logic [TLEN_W-1:0] r_count;
    logic [TLEN_W-1:0] w_count_next;
    logic              r_done;
    logic              r_flicker;
    logic              w_pre_en;
    logic              w_tick;
    logic              w_tick_eff;
    logic              w_expire;
    logic              w_flick;

    assign w_pre_en = (r_state != IDLE) && !t_freeze;

    tick_prescaler #(
        .TICK_DIV(TICK_DIV)
    ) u_prescaler (
        .clk  (clk),
        .reset(reset),
        .clr  (t_start),
        .en   (w_pre_en),
        .tick (w_tick)
    );

    // A load on the same edge swallows the tick: no decrement, no pulses.
    assign w_tick_eff   = w_tick && !t_start;
    assign w_count_next = (r_count != '0) ? r_count - 1'b1 : r_count;
    assign w_expire     = w_tick_eff && (r_count == 5'd1);
    assign w_flick      = w_tick_eff && in_window(w_count_next, FLICKER_WINDOW);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        if (t_start) begin
            w_next_state = (t_length == '0) ? IDLE : RUN;
        end else begin
            case (r_state)
                IDLE:    w_next_state = IDLE;
                RUN:     if (w_expire)      w_next_state = IDLE;
                         else if (t_freeze) w_next_state = HOLD;
                HOLD:    if (w_expire)       w_next_state = IDLE;
                         else if (!t_freeze) w_next_state = RUN;
                default: w_next_state = IDLE;
            endcase
        end
    end

    always_comb begin
        t_busy = (r_state != IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count   <= '0;
            r_done    <= 1'b0;
            r_flicker <= 1'b0;
        end else begin
            r_done    <= t_start ? (t_length == '0) : w_expire;
            r_flicker <= w_flick;
            if (t_start) begin
                r_count <= t_length;
            end else if (w_tick_eff) begin
                r_count <= w_count_next;
            end
        end
    end

    assign t_done    = r_done;
    assign t_flicker = r_flicker;

`ifdef SMART_TIMER_REMAIN_EN
    assign t_remain = r_count;
`endif

endmodule
